// File: rtl/clk_rate_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_rate_gen
// Brief    : Phase-accumulator clock generator with burst/continuous runs and
//            an increment handshake that defers updates to the wrap edge.
// Revision : 1.0  initial release
// ============================================================================
module clk_rate_gen #(
    parameter int ACC_WIDTH     = 32,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clk_ref,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [ACC_WIDTH-1:0]     inc_in,
    input  logic                     inc_valid,
    output logic                     inc_ready,
    input  logic [COUNTER_WIDTH-1:0] burst_len,
    output logic                     clk_out,
    output logic                     tick,
    output logic                     busy,
    output logic [COUNTER_WIDTH-1:0] tick_count
);

    localparam logic [ACC_WIDTH-1:0]     c_half = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [COUNTER_WIDTH-1:0] c_one  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [1:0]               r_rst_sync;
    logic                     w_rst_n;
    logic [ACC_WIDTH-1:0]     r_acc;
    logic [ACC_WIDTH-1:0]     r_inc_active;
    logic [ACC_WIDTH-1:0]     r_pend;
    logic                     r_pend_valid;
    logic [COUNTER_WIDTH-1:0] r_burst_rem;
    logic [COUNTER_WIDTH-1:0] r_tick_count;
    logic                     r_clk_out;
    logic                     r_tick;
    logic                     r_busy;
    logic [ACC_WIDTH:0]       w_sum;
    logic                     w_wrap;
    logic                     w_active;
    logic                     w_xfer;
    logic                     w_apply;
    logic                     w_to_idle;
    logic                     w_rise;
    logic [ACC_WIDTH-1:0]     w_inc_sat;

    // Assert asynchronously, release two clk_ref edges after reset_n rises.
    always_ff @(posedge clk_ref or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_sum     = {1'b0, r_acc} + {1'b0, r_inc_active};
    assign w_wrap    = w_sum[ACC_WIDTH];
    assign w_active  = (r_state != ST_IDLE);
    assign w_xfer    = inc_valid && !r_pend_valid;
    assign w_inc_sat = (inc_in > c_half) ? c_half : inc_in;
    assign w_apply   = w_active && w_wrap && r_pend_valid;
    // A wrap ends the run in STOP, or anywhere a zero increment is applied.
    assign w_to_idle = w_active && w_wrap &&
                       ((r_state == ST_STOP) || (r_pend_valid && (r_pend == '0)));
    assign w_rise    = w_active && !w_to_idle && w_sum[ACC_WIDTH-1] && !r_clk_out;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (enable && (r_inc_active != '0)) w_state_next = ST_RUN;
            ST_RUN: begin
                if (w_to_idle)
                    w_state_next = ST_IDLE;
                else if (!enable || (w_rise && (r_burst_rem == c_one)))
                    w_state_next = ST_STOP;
            end
            ST_STOP: if (w_to_idle) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_ref or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge clk_ref or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_acc        <= '0;
            r_inc_active <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_burst_rem  <= '0;
            r_tick_count <= '0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_busy <= (w_state_next != ST_IDLE);
            r_tick <= w_rise;
            if (w_rise) r_tick_count <= r_tick_count + c_one;

            if (!w_active) begin
                r_acc     <= '0;
                r_clk_out <= 1'b0;
                if (w_xfer) r_inc_active <= w_inc_sat;
                if (w_state_next == ST_RUN) r_burst_rem <= burst_len;
            end else begin
                if (w_to_idle) begin
                    r_acc     <= '0;
                    r_clk_out <= 1'b0;
                end else begin
                    r_acc     <= w_sum[ACC_WIDTH-1:0];
                    r_clk_out <= w_sum[ACC_WIDTH-1];
                end
                // Pending slot is empty whenever w_xfer is true, so these never collide.
                if (w_xfer) begin
                    r_pend       <= w_inc_sat;
                    r_pend_valid <= 1'b1;
                end
                if (w_apply) begin
                    r_inc_active <= r_pend;
                    r_pend_valid <= 1'b0;
                end
                if ((r_state == ST_RUN) && w_rise && (r_burst_rem != '0))
                    r_burst_rem <= r_burst_rem - c_one;
            end
        end
    end

    assign inc_ready  = !r_pend_valid;
    assign clk_out    = r_clk_out;
    assign tick       = r_tick;
    assign busy       = r_busy;
    assign tick_count = r_tick_count;

endmodule
`default_nettype wire

// File: tb/tb_clk_rate_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_rate_gen
// Brief    : Directed self-checking bench for clk_rate_gen (8-bit accumulator).
// Revision : 1.0  initial release
// ============================================================================
module tb_clk_rate_gen;

    logic        clk_ref;
    logic        reset_n;
    logic        enable;
    logic [7:0]  inc_in;
    logic        inc_valid;
    logic        inc_ready;
    logic [15:0] burst_len;
    logic        clk_out;
    logic        tick;
    logic        busy;
    logic [15:0] tick_count;

    int n_checks = 0;
    int n_fail   = 0;

    clk_rate_gen #(.ACC_WIDTH(8), .COUNTER_WIDTH(16)) dut (
        .clk_ref    (clk_ref),
        .reset_n    (reset_n),
        .enable     (enable),
        .inc_in     (inc_in),
        .inc_valid  (inc_valid),
        .inc_ready  (inc_ready),
        .burst_len  (burst_len),
        .clk_out    (clk_out),
        .tick       (tick),
        .busy       (busy),
        .tick_count (tick_count)
    );

    initial clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    task automatic step();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        enable    = 1'b0;
        inc_valid = 1'b0;
        inc_in    = 8'h00;
        burst_len = 16'd0;
        #1;
        repeat (2) step();
        reset_n = 1'b1;
        repeat (3) step();
    endtask

    task automatic load_inc(input logic [7:0] v);
        inc_in    = v;
        inc_valid = 1'b1;
        step();
        inc_valid = 1'b0;
    endtask

    task automatic finish_run(input string name);
        enable    = 1'b0;
        inc_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!busy) break;
        end
        n_checks++;
        if (busy !== 1'b0 || clk_out !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%b clk_out=%b expected 0/0", name, busy, clk_out);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        enable    = 1'b0;
        inc_valid = 1'b0;
        inc_in    = 8'h00;
        burst_len = 16'd0;
        #1;
        n_checks++;
        if ({clk_out, tick, busy, inc_ready} !== 4'b0001 || tick_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: clk/tick/busy/ready=%b cnt=%0d expected 0001 cnt=0",
                     {clk_out, tick, busy, inc_ready}, tick_count);
        end
        repeat (2) step();
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (6) step();
        n_checks++;
        if (busy !== 1'b0 || tick_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_zero_inc_idle: busy=%b cnt=%0d expected 0 0", busy, tick_count);
        end
        enable = 1'b0;
    endtask

    task automatic test_half_rate();
        int bad = 0;
        int nt  = 0;
        do_reset();
        load_inc(8'h80);
        enable = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (tick) nt++;
            if (k >= 2 && clk_out !== ((k % 2) == 0)) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL half_alternate: %0d bad cycles expected 0", bad);
        end
        n_checks++;
        if (nt !== 50) begin
            n_fail++;
            $display("FAIL half_ticks: got %0d expected 50", nt);
        end
        n_checks++;
        if (tick_count < 16'd49 || tick_count > 16'd50) begin
            n_fail++;
            $display("FAIL half_tick_count: got %0d expected 49..50", tick_count);
        end
        finish_run("half");
    endtask

    task automatic test_period8();
        logic [15:0] cv;
        logic [15:0] tv;
        do_reset();
        load_inc(8'h20);
        enable = 1'b1;
        step();
        n_checks++;
        if (busy !== 1'b1 || clk_out !== 1'b0) begin
            n_fail++;
            $display("FAIL p8_entry: busy=%b clk_out=%b expected 1 0", busy, clk_out);
        end
        cv = '0;
        tv = '0;
        for (int s = 1; s <= 16; s++) begin
            step();
            cv[s-1] = clk_out;
            tv[s-1] = tick;
        end
        n_checks++;
        if (cv !== 16'h7878) begin
            n_fail++;
            $display("FAIL p8_clk_out: got %h expected 7878", cv);
        end
        n_checks++;
        if (tv !== 16'h0808) begin
            n_fail++;
            $display("FAIL p8_tick: got %h expected 0808", tv);
        end
        finish_run("p8");
    endtask

    task automatic test_burst();
        logic [11:0] bv;
        logic [11:0] tv;
        do_reset();
        burst_len = 16'd3;
        load_inc(8'h40);
        enable = 1'b1;
        step();
        for (int s = 1; s <= 12; s++) begin
            step();
            bv[s-1] = busy;
            tv[s-1] = tick;
        end
        n_checks++;
        if (bv !== 12'h7FF) begin
            n_fail++;
            $display("FAIL burst_busy: got %h expected 7ff", bv);
        end
        n_checks++;
        if (tv !== 12'h222) begin
            n_fail++;
            $display("FAIL burst_tick: got %h expected 222", tv);
        end
        n_checks++;
        if (tick_count !== 16'd3 || clk_out !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_end: cnt=%0d clk_out=%b expected 3 0", tick_count, clk_out);
        end
        enable = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b0 || clk_out !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_idle: busy=%b clk_out=%b expected 0 0", busy, clk_out);
        end
    endtask

    task automatic test_update();
        int          bad = 0;
        logic [7:0]  cv;
        do_reset();
        load_inc(8'h20);
        enable = 1'b1;
        step();
        repeat (2) step();
        inc_in    = 8'h40;
        inc_valid = 1'b1;
        step();
        inc_valid = 1'b0;
        n_checks++;
        if (inc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL upd_ready_low: got %b expected 0", inc_ready);
        end
        for (int s = 4; s <= 7; s++) begin
            step();
            if (inc_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL upd_ready_hold: %0d early releases expected 0", bad);
        end
        step();
        n_checks++;
        if (inc_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL upd_ready_wrap: got %b expected 1", inc_ready);
        end
        for (int s = 0; s < 8; s++) begin
            step();
            cv[s] = clk_out;
        end
        n_checks++;
        if (cv !== 8'h66) begin
            n_fail++;
            $display("FAIL upd_period4: got %h expected 66", cv);
        end
        finish_run("upd");
    endtask

    task automatic test_back_to_back();
        logic [7:0] cv;
        do_reset();
        load_inc(8'h20);
        enable = 1'b1;
        step();
        repeat (2) step();
        inc_in    = 8'h40;
        inc_valid = 1'b1;
        step();
        inc_in = 8'h80;
        repeat (5) step();
        step();
        n_checks++;
        if (inc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second_accept: ready=%b expected 0", inc_ready);
        end
        inc_valid = 1'b0;
        cv[0] = clk_out;
        for (int s = 1; s < 8; s++) begin
            step();
            cv[s] = clk_out;
        end
        n_checks++;
        if (cv !== 8'h56) begin
            n_fail++;
            $display("FAIL b2b_clk_out: got %h expected 56", cv);
        end
        finish_run("b2b");
    endtask

    task automatic test_saturate();
        logic [7:0] cv;
        logic [7:0] tv;
        do_reset();
        load_inc(8'hFF);
        enable = 1'b1;
        step();
        for (int s = 0; s < 8; s++) begin
            step();
            cv[s] = clk_out;
            tv[s] = tick;
        end
        n_checks++;
        if (cv !== 8'h55 || tv !== 8'h55) begin
            n_fail++;
            $display("FAIL sat_period2: clk=%h tick=%h expected 55 55", cv, tv);
        end
        finish_run("sat");
    endtask

    task automatic test_zero_apply();
        do_reset();
        load_inc(8'h40);
        enable = 1'b1;
        step();
        step();
        inc_in    = 8'h00;
        inc_valid = 1'b1;
        step();
        inc_valid = 1'b0;
        step();
        n_checks++;
        if (busy !== 1'b1 || inc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_pending: busy=%b ready=%b expected 1 0", busy, inc_ready);
        end
        step();
        n_checks++;
        if (busy !== 1'b0 || inc_ready !== 1'b1 || clk_out !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_wrap_idle: busy=%b ready=%b clk=%b expected 0 1 0",
                     busy, inc_ready, clk_out);
        end
        step();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_stays_idle: busy=%b expected 0", busy);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_inc(8'h20);
        enable = 1'b1;
        step();
        repeat (2) step();
        inc_in    = 8'h40;
        inc_valid = 1'b1;
        step();
        inc_valid = 1'b0;
        repeat (2) step();
        n_checks++;
        if (clk_out !== 1'b1 || inc_ready !== 1'b0 || tick_count !== 16'd1) begin
            n_fail++;
            $display("FAIL rmid_pre: clk=%b ready=%b cnt=%0d expected 1 0 1",
                     clk_out, inc_ready, tick_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({clk_out, tick, busy, inc_ready} !== 4'b0001 || tick_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rmid_async: clk/tick/busy/ready=%b cnt=%0d expected 0001 cnt=0",
                     {clk_out, tick, busy, inc_ready}, tick_count);
        end
        repeat (2) step();
        reset_n = 1'b1;
        repeat (6) step();
        n_checks++;
        if (busy !== 1'b0 || tick_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rmid_inc_cleared: busy=%b cnt=%0d expected 0 0", busy, tick_count);
        end
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_half_rate();
        test_period8();
        test_burst();
        test_update();
        test_back_to_back();
        test_saturate();
        test_zero_apply();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_rate_gen.md
CLK_RATE_GEN -- requirements
Module: clk_rate_gen

Interface
REQ-001 Parameter ACC_WIDTH, default 32: phase accumulator width; output frequency = f(clk_ref) * inc_active / 2^ACC_WIDTH.
REQ-002 Parameter COUNTER_WIDTH, default 32: width of burst_len and tick_count.
REQ-003 clk_ref  input  1  sole clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  level; request generation.
REQ-006 inc_in  input  ACC_WIDTH  requested phase increment.
REQ-007 inc_valid  input  1  inc_in offered.
REQ-008 inc_ready  output  1  block can accept inc_in.
REQ-009 burst_len  input  COUNTER_WIDTH  ticks per run; 0 = continuous.
REQ-010 clk_out  output  1  generated square wave, registered.
REQ-011 tick  output  1  one-cycle strobe on each clk_out rising edge.
REQ-012 busy  output  1  high when state is not IDLE.
REQ-013 tick_count  output  COUNTER_WIDTH  ticks since reset.

Function
REQ-014 States IDLE, RUN, STOP; encoding is free.
REQ-015 Handshake: transfer when inc_valid && inc_ready; inc_valid may be held without loss.
REQ-016 Accepted inc_in above 2^(ACC_WIDTH-1) is saturated to 2^(ACC_WIDTH-1).
REQ-017 Transfer in IDLE: value written to inc_active on the same edge; inc_ready stays 1.
REQ-018 Transfer in RUN/STOP: value held in a pending register; inc_ready goes 0 until the pending value is applied.
REQ-019 Wrap cycle: carry out of acc + inc_active is set.
REQ-020 Pending value: applied to inc_active on the wrap edge, which then still uses the old increment; inc_ready returns to 1 on that edge.
REQ-021 IDLE: acc = 0, clk_out = 0; enable && inc_active != 0 -> RUN; burst_rem <= burst_len on that edge; no accumulation on the entry edge.
REQ-022 RUN/STOP: acc <= acc + inc_active mod 2^ACC_WIDTH on every edge.
REQ-023 RUN/STOP: clk_out <= MSB of the new acc.
REQ-024 tick: high for the one cycle in which clk_out changes 0->1.
REQ-025 Continuous run (burst_len = 0): burst_rem is not decremented.
REQ-026 Burst run (burst_len != 0): burst_rem decrements on each tick; tick with burst_rem == 1 -> STOP.
REQ-027 RUN with enable == 0 -> STOP; a simultaneous final-burst tick is still counted.
REQ-028 STOP: accumulate to the next wrap edge, then -> IDLE; on that edge acc <= 0 and clk_out <= 0; enable is ignored in STOP.
REQ-029 Applying inc_active = 0 at a wrap edge -> IDLE on that edge.
REQ-030 tick_count increments on every tick, wrapping modulo 2^COUNTER_WIDTH; it is never cleared except by reset.
REQ-031 busy is a registered state decode, with no combinational path from inputs.

Reset
REQ-032 reset_n low forces immediately, without a clock: state IDLE; acc, inc_active, pending, burst_rem, tick_count = 0; clk_out, tick, busy = 0; inc_ready = 1.
REQ-033 reset_n low mid-operation aborts the run with no final tick; any pending increment is discarded.
REQ-034 Release of reset_n is synchronised internally to clk_ref (two-flop deassert).

Verification (ACC_WIDTH = 8, COUNTER_WIDTH = 16)
REQ-035 inc 0x80, burst 0, enable held 100 cycles -> clk_out alternates every cycle; tick every 2 cycles; tick_count 49..50.
REQ-036 inc 0x20, continuous -> clk_out period 8 (4 high, 4 low); first tick 4 cycles after RUN entry.
REQ-037 inc 0x40, burst 3, enable held -> exactly 3 ticks; busy falls on the wrap edge after the 3rd tick; clk_out 0 in IDLE.
REQ-038 inc 0x20 running, offer 0x40 mid-period -> inc_ready 0 until the next wrap, then clk_out period 4.
REQ-039 inc_in 0xFF accepted -> behaves as 0x80 (period 2).
REQ-040 reset_n pulsed low mid-high-phase -> clk_out, tick, busy, tick_count 0 before the next edge; inc_ready 1.
